// File: rtl/countup_timer_pkg.sv
//----------------------------------------------------------------------------
// countup_pkg: shared state encoding and width constants for countup_timer.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

package countup_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int COUNT_W = 32;
  localparam int PRESC_W = 16;

endpackage

`default_nettype wire

// File: rtl/countup_timer_tick_gen.sv
//----------------------------------------------------------------------------
// tick_gen: prescaler that pulses tick_o once every PRESCALE enabled cycles.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tick_gen
  import countup_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic resetN,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic               at_last;

  assign at_last = (presc_q == LAST);
  assign tick_o  = en_i & at_last;

  // Clear dominates enable so a restart always begins a fresh phase.
  always_comb begin
    presc_d = presc_q;
    if (clr_i) begin
      presc_d = '0;
    end else if (en_i) begin
      presc_d = at_last ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetN) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/countup_timer.sv
//----------------------------------------------------------------------------
// countup_timer: prescaled count-up timer with run/pause FSM, target compare
// and lap capture. Build macro COUNTUP_AUTORELOAD_EN selects reload-on-target.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module countup_timer
  import countup_pkg::*;
#(
  parameter int WIDTH    = COUNT_W,
  parameter int PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             resetN,
  input  logic             active_i,
  input  logic             startStop_i,
  input  logic             clear_i,
  input  logic             lap_i,
  input  logic [WIDTH-1:0] target_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] lapCount_o,
  output logic             lapValid_o,
  output logic             running_o,
  output logic             done_o,
  output logic             overflow_o
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   lap_q, lap_d;
  logic               lapv_q, lapv_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic               tick;
  logic               presc_en;
  logic               presc_clr;
  logic               at_target;

  assign presc_en  = active_i & (state_q == ST_RUN);
  assign presc_clr = active_i & (clear_i | ((state_q == ST_IDLE) & startStop_i));
  assign at_target = (target_i != '0) && (count_q >= target_i);

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .CLK    (CLK),
    .resetN (resetN),
    .clr_i  (presc_clr),
    .en_i   (presc_en),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lap_d   = lap_q;
    lapv_d  = lapv_q;
    done_d  = done_q;
    ovf_d   = ovf_q;

    if (active_i) begin
`ifdef COUNTUP_AUTORELOAD_EN
      done_d = 1'b0;
`endif
      if (clear_i) begin
        state_d = ST_IDLE;
        count_d = '0;
        lapv_d  = 1'b0;
        ovf_d   = 1'b0;
      end else begin
        // Lap samples the count as it stood before any same-cycle increment.
        if (lap_i && (state_q != ST_IDLE)) begin
          lap_d  = count_q;
          lapv_d = 1'b1;
        end

        case (state_q)
          ST_IDLE: begin
            count_d = '0;
            if (startStop_i) begin
              state_d = ST_RUN;
            end
          end
          ST_RUN: begin
            if (at_target) begin
`ifdef COUNTUP_AUTORELOAD_EN
              count_d = '0;
              done_d  = 1'b1;
`else
              state_d = ST_DONE;
`endif
            end else if (tick) begin
              if (count_q == '1) begin
                ovf_d = 1'b1;
              end else begin
                count_d = count_q + 1'b1;
              end
            end
            if (startStop_i) begin
              state_d = ST_PAUSE;
            end
          end
          ST_PAUSE: begin
            if (startStop_i) begin
              state_d = ST_RUN;
            end
          end
          ST_DONE: begin
          end
        endcase
      end

`ifndef COUNTUP_AUTORELOAD_EN
      done_d = (state_d == ST_DONE);
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      lap_q   <= '0;
      lapv_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lap_q   <= lap_d;
      lapv_q  <= lapv_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o    = count_q;
  assign lapCount_o = lap_q;
  assign lapValid_o = lapv_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign running_o  = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: doc/countup_timer.md
Name: countup_timer

Overview:
- Count-up elapsed-time counter; the counterpart to the countdown block on the clock board.
- Counts prescaled ticks from 0 towards a programmable target under a start/pause run-control FSM.
- Flags completion, and captures lap values.
- Sits beside the countdown in the clock datapath and feeds the 7-segment display mux and LED logic.

Parameters:
- WIDTH, 32, width of count, target and lap values.
- PRESCALE, 1, CLK cycles per count unit; legal range 1..2^16.

Ports:
- CLK  input  1  clock, all logic on posedge.
- resetN  input  1  synchronous, active-low reset.
- active  input  1  block enable; when 0, all state (FSM, prescaler, count, lap) is frozen.
- startStop  input  1  single-cycle pulse; toggles run/pause.
- clear  input  1  single-cycle pulse; returns to IDLE with count 0.
- lap  input  1  single-cycle pulse; captures the current count.
- target  input  WIDTH  completion value; 0 means no limit (free-run).
- count  output  WIDTH  current elapsed count.
- lapCount  output  WIDTH  last captured count.
- lapValid  output  1  lapCount holds a capture since the last clear/reset.
- running  output  1  FSM is in RUN.
- done  output  1  see Behaviour.
- overflow  output  1  sticky; free-run count saturated.

Behaviour:
- Reset: resetN=0 at a posedge is unconditional and ignores active. Result: FSM=IDLE, prescaler=0, count=0, lapCount=0, lapValid=0, done=0, overflow=0, running=0.
- Gating: all remaining behaviour below applies only when active=1; otherwise every register holds its value.
- Priority per cycle: reset > clear > startStop > tick/target logic. lap is evaluated in parallel with the others.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE: count=0. startStop -> RUN, prescaler cleared.
  - RUN: startStop -> PAUSE. The increment (if any) in the same cycle is still performed.
  - PAUSE: count and prescaler hold. startStop -> RUN, resuming from the retained prescaler phase.
  - DONE: startStop ignored. Only clear or reset exits.
  - clear in any state -> IDLE: count=0, prescaler=0, lapValid=0, overflow=0, done=0. lapCount is kept. A startStop in the same cycle is ignored.
- Prescaler: in RUN it counts 0..PRESCALE-1 and wraps. A tick is asserted in the cycle where prescaler==PRESCALE-1. With PRESCALE=1, every RUN cycle is a tick.
- Increment: on a tick in RUN, count <= count+1, subject to the target and saturation rules below. First increment occurs PRESCALE cycles after the startStop pulse.
- Target compare, each RUN cycle, evaluated on the registered count:
  - If target!=0 and count>=target: FSM -> DONE and no increment that cycle.
  - Consequently, count reaches target on a tick and DONE is entered on the following cycle.
  - Lowering target below count while running forces DONE on the next cycle.
  - Changing target during PAUSE takes effect on resume.
- done: level, high while FSM=DONE. It is registered, so it rises 1 cycle after the increment that made count==target.
- Free-run (target==0): count saturates at 2^WIDTH-1 and never wraps. On the tick that would wrap, overflow <= 1 and count holds; the FSM stays in RUN.
- lap:
  - RUN or PAUSE: lapCount <= count (value before any same-cycle increment) and lapValid <= 1.
  - DONE: also captures.
  - IDLE: ignored.
  - lap and clear in the same cycle: clear wins, and the lap capture is also suppressed.
- Outputs are all registered, except running, which is decoded directly from the FSM state.

Optional Feature:
- Macro: COUNTUP_AUTORELOAD_EN.
- Defined: DONE is unreachable.
  - When count>=target (target!=0) in RUN, count <= 0 and the FSM stays in RUN.
  - The prescaler continues its phase.
  - done becomes a 1-cycle pulse, asserted in the cycle after reload.
  - The reloading cycle does not increment.
- Undefined: hold in DONE as specified above.

Decomposition:
- Package countup_pkg holds:
  - state enum (IDLE, RUN, PAUSE, DONE), 2-bit encoding;
  - COUNT_W default constant;
  - PRESCALE width constant (16).
- One natural sub-module, tick_gen: prescaler with clear, enable (RUN & active) and tick output, parameterised by PRESCALE.
- FSM, count, lap and compare logic stay in countup_timer.

Test Plan:
- PRESCALE=4, target=3: reset, startStop. Required: count=1 at cycle 4, 2 at 8, 3 at 12; done=1 and running=0 at cycle 13; count holds 3 for 20 more cycles.
- PRESCALE=1, target=0: start, pause at count=5, hold 10 cycles, resume. Required: count stays 5 during pause, then continues 6,7,…; lap at count=7 gives lapCount=7 and lapValid=1.
- WIDTH=4, target=0: run past 15. Required: count saturates at 15, overflow=1, running=1; clear gives count=0, overflow=0, FSM IDLE.
- clear+startStop in the same cycle during RUN: FSM=IDLE, count=0, running=0. active=0 for 8 cycles mid-RUN: count and prescaler frozen, with no lost or extra ticks.
- Running at count=9, target changed from 20 to 5: done=1 on the next cycle and count holds 9. resetN=0 mid-RUN with active=0: all outputs return to their reset values.
- COUNTUP_AUTORELOAD_EN, PRESCALE=1, target=2: count sequence 0,1,2,0,1,2…; one 1-cycle done pulse per reload; running stays 1.
